// File: rtl/read_registers_q.sv
// read_registers_q
//   Register-read stage between decode and execute. Decoded instructions go
//   into an in-order circular queue of DEPTH entries. The head entry's source
//   indices go to the register file. The head issues to execute once no
//   unresolved RAW hazard remains against the NUM_HAZ downstream writer
//   stages. Index 0 of the hazard ports is the youngest stage (execute).
//
// Handshake semantics (both sides):
//   - Decode side: an entry is accepted in a cycle when decode_valid=1 and
//     decode_stall=0. When decode_valid=1 and decode_stall=1, decode must hold
//     the entry stable. decode_stall is only asserted while decode_valid=1.
//   - Execute side: valid=1 means the head entry is issued this cycle and is
//     consumed. valid already accounts for stall, so execute never sees
//     valid=1 while it is stalling.
//   - flush overrides everything. In the flush cycle nothing issues, nothing
//     is accepted, decode_stall=0, and the queue is empty from the next cycle.
//
// Optional feature (compile-time macro RR_FORWARD_EN):
//   - When defined, a hazard is resolved when the governing writer stage has
//     haz_data_ok set. The operand is then taken from haz_data for that stage.
//   - When undefined, any hazard blocks, and the operand values always come
//     from the register file.
//
// Ports:
//   clk, reset (async, active-high), flush
//   decode_* fields and decode_valid/decode_exception_*, decode_stall out
//   read_rs1/read_rs2 out, rs1_val/rs2_val in (register file)
//   haz_rd/haz_valid/haz_data/haz_data_ok in (downstream writers)
//   *_out head entry fields, rs*_val_out operands, exception_*_out
//   valid out (issue), stall in (execute back-pressure)

module read_registers_q #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 2,
  parameter int NUM_HAZ = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [6:0]              decode_opcode,
  input  logic [4:0]              decode_rd,
  input  logic [4:0]              decode_rs1,
  input  logic [4:0]              decode_rs2,
  input  logic [2:0]              decode_funct3,
  input  logic [6:0]              decode_funct7,
  input  logic [XLEN-1:0]         decode_imm,
  input  logic [XLEN-1:0]         decode_pc,
  input  logic                    decode_valid,
  input  logic [5:0]              decode_exception_num,
  input  logic                    decode_exception_valid,
  output logic                    decode_stall,
  output logic [4:0]              read_rs1,
  output logic [4:0]              read_rs2,
  input  logic [XLEN-1:0]         rs1_val,
  input  logic [XLEN-1:0]         rs2_val,
  input  logic [5*NUM_HAZ-1:0]    haz_rd,
  input  logic [NUM_HAZ-1:0]      haz_valid,
  input  logic [XLEN*NUM_HAZ-1:0] haz_data,
  input  logic [NUM_HAZ-1:0]      haz_data_ok,
  output logic [6:0]              opcode_out,
  output logic [4:0]              rd_out,
  output logic [4:0]              rs1_out,
  output logic [4:0]              rs2_out,
  output logic [2:0]              funct3_out,
  output logic [6:0]              funct7_out,
  output logic [XLEN-1:0]         imm_out,
  output logic [XLEN-1:0]         pc_out,
  output logic [XLEN-1:0]         rs1_val_out,
  output logic [XLEN-1:0]         rs2_val_out,
  output logic [5:0]              exception_num_out,
  output logic                    exception_valid_out,
  output logic                    valid,
  input  logic                    stall
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

`ifdef RR_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  typedef struct packed {
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [5:0]      exc_num;
    logic            exc_valid;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;

  entry_t          w_head;
  entry_t          w_new;
  logic            w_rs1_hit, w_rs2_hit;
  logic            w_rs1_ok, w_rs2_ok;
  logic [XLEN-1:0] w_rs1_fwd, w_rs2_fwd;
  logic            w_blocked;
  logic            w_advance;
  logic            w_ingest;

  assign w_head = r_mem[r_rd_ptr];

  always_comb begin
    w_new           = '0;
    w_new.opcode    = decode_opcode;
    w_new.rd        = decode_rd;
    w_new.rs1       = decode_rs1;
    w_new.rs2       = decode_rs2;
    w_new.funct3    = decode_funct3;
    w_new.funct7    = decode_funct7;
    w_new.imm       = decode_imm;
    w_new.pc        = decode_pc;
    w_new.exc_num   = decode_exception_num;
    w_new.exc_valid = decode_exception_valid;
  end

  // Hazard search. The loop runs from oldest to youngest stage, so the lowest
  // matching index is written last and governs. x0 never carries a hazard.
  always_comb begin
    w_rs1_hit = 1'b0;
    w_rs2_hit = 1'b0;
    w_rs1_ok  = 1'b0;
    w_rs2_ok  = 1'b0;
    w_rs1_fwd = '0;
    w_rs2_fwd = '0;
    for (int i = NUM_HAZ - 1; i >= 0; i--) begin
      if (haz_valid[i] && (haz_rd[i*5 +: 5] == w_head.rs1)) begin
        w_rs1_hit = 1'b1;
        w_rs1_ok  = haz_data_ok[i];
        w_rs1_fwd = haz_data[i*XLEN +: XLEN];
      end
      if (haz_valid[i] && (haz_rd[i*5 +: 5] == w_head.rs2)) begin
        w_rs2_hit = 1'b1;
        w_rs2_ok  = haz_data_ok[i];
        w_rs2_fwd = haz_data[i*XLEN +: XLEN];
      end
    end
    if (w_head.rs1 == 5'd0) w_rs1_hit = 1'b0;
    if (w_head.rs2 == 5'd0) w_rs2_hit = 1'b0;
  end

  // Without forwarding FWD_EN is 0, so any hit blocks.
  assign w_blocked = (w_rs1_hit & ~(FWD_EN & w_rs1_ok)) |
                     (w_rs2_hit & ~(FWD_EN & w_rs2_ok));

  // An exception entry skips the hazard check because its operands are unused.
  assign w_advance = ~flush & ~stall & (r_count != '0) &
                     (w_head.exc_valid | ~w_blocked);

  // A full queue can still accept an entry when the head leaves in the same cycle.
  assign w_ingest  = ~flush & decode_valid &
                     ((r_count < FULL_CNT) | w_advance);

  assign decode_stall = ~flush & decode_valid & ~w_ingest;
  assign valid        = w_advance;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      // Drop every entry. The read pointer catches up with the write pointer.
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_ingest) begin
        r_mem[r_wr_ptr] <= w_new;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_advance) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (AW + 1)'(w_ingest) - (AW + 1)'(w_advance);
    end
  end

  assign read_rs1            = w_head.rs1;
  assign read_rs2            = w_head.rs2;
  assign opcode_out          = w_head.opcode;
  assign rd_out              = w_head.rd;
  assign rs1_out             = w_head.rs1;
  assign rs2_out             = w_head.rs2;
  assign funct3_out          = w_head.funct3;
  assign funct7_out          = w_head.funct7;
  assign imm_out             = w_head.imm;
  assign pc_out              = w_head.pc;
  assign exception_num_out   = w_head.exc_num;
  assign exception_valid_out = w_head.exc_valid;

  assign rs1_val_out = (FWD_EN && w_rs1_hit && w_rs1_ok) ? w_rs1_fwd : rs1_val;
  assign rs2_val_out = (FWD_EN && w_rs2_hit && w_rs2_ok) ? w_rs2_fwd : rs2_val;

endmodule

// File: tb/tb_read_registers_q.sv
// Testbench for read_registers_q with the default parameters (XLEN=32,
// DEPTH=2, NUM_HAZ=2). Inputs change on the falling edge. Outputs are checked
// 1ns later, so they are stable before the next rising edge.
// The register file model returns A000_00xx for rs1 and B000_00xx for rs2,
// where xx is the index.

module tb_read_registers_q;

  localparam int XLEN = 32;
  localparam int NH   = 2;

  logic            clk, reset, flush;
  logic [6:0]      decode_opcode;
  logic [4:0]      decode_rd, decode_rs1, decode_rs2;
  logic [2:0]      decode_funct3;
  logic [6:0]      decode_funct7;
  logic [XLEN-1:0] decode_imm, decode_pc;
  logic            decode_valid;
  logic [5:0]      decode_exception_num;
  logic            decode_exception_valid;
  logic            decode_stall;
  logic [4:0]      read_rs1, read_rs2;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [5*NH-1:0]    haz_rd;
  logic [NH-1:0]      haz_valid;
  logic [XLEN*NH-1:0] haz_data;
  logic [NH-1:0]      haz_data_ok;
  logic [6:0]      opcode_out;
  logic [4:0]      rd_out, rs1_out, rs2_out;
  logic [2:0]      funct3_out;
  logic [6:0]      funct7_out;
  logic [XLEN-1:0] imm_out, pc_out, rs1_val_out, rs2_val_out;
  logic [5:0]      exception_num_out;
  logic            exception_valid_out;
  logic            valid;
  logic            stall;

  int n_checks = 0;
  int n_pass   = 0;

  read_registers_q #(.XLEN(XLEN), .DEPTH(2), .NUM_HAZ(NH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .decode_opcode(decode_opcode), .decode_rd(decode_rd),
    .decode_rs1(decode_rs1), .decode_rs2(decode_rs2),
    .decode_funct3(decode_funct3), .decode_funct7(decode_funct7),
    .decode_imm(decode_imm), .decode_pc(decode_pc),
    .decode_valid(decode_valid),
    .decode_exception_num(decode_exception_num),
    .decode_exception_valid(decode_exception_valid),
    .decode_stall(decode_stall),
    .read_rs1(read_rs1), .read_rs2(read_rs2),
    .rs1_val(rs1_val), .rs2_val(rs2_val),
    .haz_rd(haz_rd), .haz_valid(haz_valid),
    .haz_data(haz_data), .haz_data_ok(haz_data_ok),
    .opcode_out(opcode_out), .rd_out(rd_out), .rs1_out(rs1_out),
    .rs2_out(rs2_out), .funct3_out(funct3_out), .funct7_out(funct7_out),
    .imm_out(imm_out), .pc_out(pc_out),
    .rs1_val_out(rs1_val_out), .rs2_val_out(rs2_val_out),
    .exception_num_out(exception_num_out),
    .exception_valid_out(exception_valid_out),
    .valid(valid), .stall(stall)
  );

  // Clock / register file model.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rs1_val = 32'hA000_0000 | {27'd0, read_rs1};
  assign rs2_val = 32'hB000_0000 | {27'd0, read_rs2};

  // Driver tasks.
  task automatic set_dec(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [XLEN-1:0] imm);
    decode_valid           = v;
    decode_opcode          = 7'h33;
    decode_rd              = rd;
    decode_rs1             = rs1;
    decode_rs2             = rs2;
    decode_funct3          = rd[2:0];
    decode_funct7          = 7'h00;
    decode_imm             = imm;
    decode_pc              = 32'h0000_1000 + {25'd0, rd, 2'b00};
    decode_exception_num   = 6'd0;
    decode_exception_valid = 1'b0;
  endtask

  task automatic clear_haz();
    haz_rd      = '0;
    haz_valid   = '0;
    haz_data    = '0;
    haz_data_ok = '0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; stall = 1'b0;
    set_dec(1'b0, 5'd0, 5'd0, 5'd0, '0);
    clear_haz();
    #1;
    n_checks++; if (valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", valid); else n_pass++;
    n_checks++; if (decode_stall !== 1'b0) $display("FAIL rst_dstall: got %b want 0", decode_stall); else n_pass++;
    n_checks++; if ({opcode_out, rd_out, read_rs1, read_rs2, exception_valid_out} !== 23'd0)
      $display("FAIL rst_fields: got %h want 0", {opcode_out, rd_out, read_rs1, read_rs2, exception_valid_out}); else n_pass++;
    n_checks++; if ({imm_out, pc_out} !== 64'd0) $display("FAIL rst_imm_pc: got %h want 0", {imm_out, pc_out}); else n_pass++;
    repeat (2) @(posedge clk);
    step();
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    step(); set_dec(1'b1, 5'd1, 5'd2, 5'd3, 32'h11); #1;
    n_checks++; if (valid !== 1'b0) $display("FAIL b2b_empty_valid: got %b want 0", valid); else n_pass++;
    n_checks++; if (decode_stall !== 1'b0) $display("FAIL b2b_dstall0: got %b want 0", decode_stall); else n_pass++;
    step(); set_dec(1'b1, 5'd2, 5'd4, 5'd5, 32'h22); #1;
    n_checks++; if (valid !== 1'b1 || rd_out !== 5'd1) $display("FAIL b2b_issue1: got valid=%b rd=%0d want 1/1", valid, rd_out); else n_pass++;
    n_checks++; if (rs1_val_out !== 32'hA000_0002 || rs2_val_out !== 32'hB000_0003)
      $display("FAIL b2b_operands: got %h %h want a0000002 b0000003", rs1_val_out, rs2_val_out); else n_pass++;
    n_checks++; if (imm_out !== 32'h11 || pc_out !== 32'h1004 || funct3_out !== 3'd1 || opcode_out !== 7'h33)
      $display("FAIL b2b_fields: got imm=%h pc=%h f3=%0d op=%h want 11/1004/1/33", imm_out, pc_out, funct3_out, opcode_out); else n_pass++;
    n_checks++; if (decode_stall !== 1'b0) $display("FAIL b2b_dstall1: got %b want 0", decode_stall); else n_pass++;
    step(); set_dec(1'b1, 5'd3, 5'd6, 5'd7, 32'h33); #1;
    n_checks++; if (valid !== 1'b1 || rd_out !== 5'd2 || decode_stall !== 1'b0)
      $display("FAIL b2b_issue2: got valid=%b rd=%0d dstall=%b want 1/2/0", valid, rd_out, decode_stall); else n_pass++;
    step(); set_dec(1'b0, 5'd0, 5'd0, 5'd0, '0); #1;
    n_checks++; if (valid !== 1'b1 || rd_out !== 5'd3 || read_rs1 !== 5'd6)
      $display("FAIL b2b_issue3: got valid=%b rd=%0d rs1=%0d want 1/3/6", valid, rd_out, read_rs1); else n_pass++;
    step(); #1;
    n_checks++; if (valid !== 1'b0) $display("FAIL b2b_drained: got %b want 0", valid); else n_pass++;
  endtask

  task automatic test_hazard_stall();
    step(); set_dec(1'b1, 5'd10, 5'd5, 5'd0, '0);
    haz_valid = 2'b01; haz_rd = {5'd0, 5'd5}; #1;
    n_checks++; if (valid !== 1'b0 || decode_stall !== 1'b0) $display("FAIL haz_ingest: got valid=%b dstall=%b want 0/0", valid, decode_stall); else n_pass++;
    step(); set_dec(1'b1, 5'd11, 5'd0, 5'd0, '0); #1;
    n_checks++; if (valid !== 1'b0 || decode_stall !== 1'b0) $display("FAIL haz_blk1: got valid=%b dstall=%b want 0/0", valid, decode_stall); else n_pass++;
    step(); set_dec(1'b1, 5'd12, 5'd0, 5'd0, '0); #1;
    n_checks++; if (valid !== 1'b0 || decode_stall !== 1'b1) $display("FAIL haz_blk2_full: got valid=%b dstall=%b want 0/1", valid, decode_stall); else n_pass++;
    step(); clear_haz(); #1;
    n_checks++; if (valid !== 1'b1 || rd_out !== 5'd10 || decode_stall !== 1'b0)
      $display("FAIL haz_release: got valid=%b rd=%0d dstall=%b want 1/10/0", valid, rd_out, decode_stall); else n_pass++;
    step(); set_dec(1'b0, 5'd0, 5'd0, 5'd0, '0); #1;
    n_checks++; if (valid !== 1'b1 || rd_out !== 5'd11) $display("FAIL haz_drain1: got valid=%b rd=%0d want 1/11", valid, rd_out); else n_pass++;
    step(); #1;
    n_checks++; if (valid !== 1'b1 || rd_out !== 5'd12) $display("FAIL haz_drain2: got valid=%b rd=%0d want 1/12", valid, rd_out); else n_pass++;
    step(); #1;
    n_checks++; if (valid !== 1'b0) $display("FAIL haz_empty: got %b want 0", valid); else n_pass++;
  endtask

  task automatic test_x0_and_inactive();
    // Stage 1 writes x0, and stage 0 names x4 but is not valid. Neither blocks.
    step(); set_dec(1'b1, 5'd13, 5'd4, 5'd0, '0);
    haz_valid = 2'b10; haz_rd = {5'd0, 5'd4};
    step(); set_dec(1'b0, 5'd0, 5'd0, 5'd0, '0); #1;
    n_checks++; if (valid !== 1'b1 || rd_out !== 5'd13) $display("FAIL x0_issue: got valid=%b rd=%0d want 1/13", valid, rd_out); else n_pass++;
    n_checks++; if (rs2_val_out !== 32'hB000_0000) $display("FAIL x0_rs2val: got %h want b0000000", rs2_val_out); else n_pass++;
    step(); clear_haz(); #1;
    n_checks++; if (valid !== 1'b0) $display("FAIL x0_empty: got %b want 0", valid); else n_pass++;
  endtask

  task automatic test_forward();
    // Both stages write x7. Stage 0 governs and its data is not ready.
    step(); set_dec(1'b1, 5'd14, 5'd7, 5'd0, '0);
    haz_valid = 2'b11; haz_rd = {5'd7, 5'd7};
    haz_data_ok = 2'b10; haz_data = {32'h0000_00AA, 32'h0000_0000};
    step(); set_dec(1'b0, 5'd0, 5'd0, 5'd0, '0); #1;
    n_checks++; if (valid !== 1'b0) $display("FAIL fwd_blocked: got %b want 0", valid); else n_pass++;
    step(); haz_data_ok = 2'b11; haz_data = {32'h0000_00AA, 32'h0000_0055}; #1;
`ifdef RR_FORWARD_EN
    n_checks++; if (valid !== 1'b1) $display("FAIL fwd_issue: got %b want 1", valid); else n_pass++;
    n_checks++; if (rs1_val_out !== 32'h0000_0055) $display("FAIL fwd_rs1val: got %h want 00000055", rs1_val_out); else n_pass++;
    step(); clear_haz(); #1;
`else
    n_checks++; if (valid !== 1'b0) $display("FAIL nofwd_blocked: got %b want 0", valid); else n_pass++;
    step(); clear_haz(); #1;
    n_checks++; if (valid !== 1'b1 || rs1_val_out !== 32'hA000_0007)
      $display("FAIL nofwd_issue: got valid=%b rs1val=%h want 1/a0000007", valid, rs1_val_out); else n_pass++;
    step(); #1;
`endif
    n_checks++; if (valid !== 1'b0) $display("FAIL fwd_empty: got %b want 0", valid); else n_pass++;
  endtask

  task automatic test_exception();
    step(); set_dec(1'b1, 5'd15, 5'd9, 5'd0, '0);
    decode_exception_valid = 1'b1; decode_exception_num = 6'd2;
    haz_valid = 2'b01; haz_rd = {5'd0, 5'd9};
    step(); set_dec(1'b0, 5'd0, 5'd0, 5'd0, '0); #1;
    n_checks++; if (valid !== 1'b1 || exception_valid_out !== 1'b1 || exception_num_out !== 6'd2)
      $display("FAIL exc_issue: got valid=%b ev=%b en=%0d want 1/1/2", valid, exception_valid_out, exception_num_out); else n_pass++;
    step(); clear_haz(); #1;
    n_checks++; if (valid !== 1'b0) $display("FAIL exc_empty: got %b want 0", valid); else n_pass++;
  endtask

  task automatic test_stall_fill();
    step(); stall = 1'b1; set_dec(1'b1, 5'd16, 5'd1, 5'd1, '0);
    step(); set_dec(1'b1, 5'd17, 5'd1, 5'd1, '0); #1;
    n_checks++; if (valid !== 1'b0 || decode_stall !== 1'b0) $display("FAIL stl_fill1: got valid=%b dstall=%b want 0/0", valid, decode_stall); else n_pass++;
    step(); set_dec(1'b1, 5'd18, 5'd1, 5'd1, '0); #1;
    n_checks++; if (valid !== 1'b0 || decode_stall !== 1'b1 || rd_out !== 5'd16)
      $display("FAIL stl_full: got valid=%b dstall=%b rd=%0d want 0/1/16", valid, decode_stall, rd_out); else n_pass++;
    step(); stall = 1'b0; set_dec(1'b0, 5'd0, 5'd0, 5'd0, '0); #1;
    n_checks++; if (valid !== 1'b1 || rd_out !== 5'd16) $display("FAIL stl_release: got valid=%b rd=%0d want 1/16", valid, rd_out); else n_pass++;
    step(); stall = 1'b1; #1;
  endtask

  task automatic test_flush();
    // Queue holds rd=17 from the previous task. Fill it with rd=19.
    step(); set_dec(1'b1, 5'd19, 5'd1, 5'd1, '0);
    step(); set_dec(1'b1, 5'd20, 5'd1, 5'd1, '0); flush = 1'b1; stall = 1'b0; #1;
    n_checks++; if (valid !== 1'b0 || decode_stall !== 1'b0) $display("FAIL fl_cycle: got valid=%b dstall=%b want 0/0", valid, decode_stall); else n_pass++;
    step(); flush = 1'b0; set_dec(1'b1, 5'd22, 5'd1, 5'd1, '0); #1;
    n_checks++; if (valid !== 1'b0 || decode_stall !== 1'b0) $display("FAIL fl_empty: got valid=%b dstall=%b want 0/0", valid, decode_stall); else n_pass++;
    step(); set_dec(1'b0, 5'd0, 5'd0, 5'd0, '0); #1;
    n_checks++; if (valid !== 1'b1 || rd_out !== 5'd22) $display("FAIL fl_next: got valid=%b rd=%0d want 1/22", valid, rd_out); else n_pass++;
    step(); #1;
    n_checks++; if (valid !== 1'b0) $display("FAIL fl_drained: got %b want 0", valid); else n_pass++;
  endtask

  task automatic test_async_reset();
    step(); set_dec(1'b1, 5'd25, 5'd3, 5'd3, 32'h77);
    step(); set_dec(1'b0, 5'd0, 5'd0, 5'd0, '0); #1;
    n_checks++; if (valid !== 1'b1 || rd_out !== 5'd25) $display("FAIL ar_pre: got valid=%b rd=%0d want 1/25", valid, rd_out); else n_pass++;
    reset = 1'b1; #1;
    n_checks++; if (valid !== 1'b0 || rd_out !== 5'd0 || imm_out !== 32'd0)
      $display("FAIL ar_clear: got valid=%b rd=%0d imm=%h want 0/0/0", valid, rd_out, imm_out); else n_pass++;
    step(); reset = 1'b0; #1;
    n_checks++; if (valid !== 1'b0) $display("FAIL ar_after: got %b want 0", valid); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_hazard_stall();
    test_x0_and_inactive();
    test_forward();
    test_exception();
    test_stall_fill();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/read_registers_q.md
# read_registers_q

Parametrised register-read stage between decode and execute. Buffers up to DEPTH decoded instructions in an in-order queue, presents the head entry's source indices to the register file, and issues it to execute once no unresolved RAW hazard remains against any of NUM_HAZ downstream writer stages. Optionally resolves hazards by forwarding instead of stalling. Successor to the single-entry, single-hazard-port read stage.

## Interface
Parameters:
- XLEN, 32, data/imm/pc width
- DEPTH, 2, queue entries; power of two, ≥2
- NUM_HAZ, 2, downstream writer stages checked; index 0 is the youngest (execute)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  discard all queued entries
- decode_opcode/rd/rs1/rs2/funct3/funct7  in  7/5/5/5/3/7  decoded fields
- decode_imm, decode_pc  in  XLEN  immediate, pc
- decode_valid  in  1  decode offers an entry
- decode_exception_num  in  6;  decode_exception_valid  in  1
- decode_stall  out  1  entry not accepted this cycle
- read_rs1, read_rs2  out  5  register-file read indices (head entry)
- rs1_val, rs2_val  in  XLEN  register-file read data (combinational)
- haz_rd  in  5*NUM_HAZ  destination index per writer stage
- haz_valid  in  NUM_HAZ  writer stage holds a register-writing instruction
- haz_data  in  XLEN*NUM_HAZ  result per stage (used only with forwarding)
- haz_data_ok  in  NUM_HAZ  haz_data valid this cycle (used only with forwarding)
- opcode_out, rd_out, rs1_out, rs2_out, funct3_out, funct7_out, imm_out, pc_out  out  field widths  head entry
- rs1_val_out, rs2_val_out  out  XLEN  operand values
- exception_num_out  out  6;  exception_valid_out  out  1
- valid  out  1  head entry issued this cycle
- stall  in  1  execute cannot accept

## Operation
- Queue: circular buffer, wr_ptr/rd_ptr of log2(DEPTH) bits wrapping naturally, count of log2(DEPTH)+1 bits.
- Hazard for source s (rs1/rs2) of head: s≠0 and ∃i haz_valid[i] && haz_rd[i]==s. The lowest matching i governs.
- blocked = hazard on rs1 or rs2 that is unresolved (without forwarding: any hazard is unresolved).
- advance = ~flush & ~stall & count≠0 & (head.exception_valid | ~blocked); valid = advance.
- ingest = ~flush & decode_valid & (count<DEPTH | advance). Simultaneous ingest and advance on a full queue is legal; count unchanged.
- decode_stall = ~flush & decode_valid & ~ingest.
- count_next: flush→0; else count + ingest − advance.
- Outputs are combinational from the head entry; read_rs1/rs2 = head.rs1/rs2. With count==0, outputs show the stale slot at rd_ptr and valid=0.
- rs*_val_out = rs*_val unless forwarded (see Configuration).
- Exception entries issue regardless of hazards; operand values are don't-care.

## Timing
- Reset (async): count, pointers, every slot cleared to 0; all field outputs 0, valid 0, decode_stall 0.
- Latency: entry ingested in cycle N is head at N+1 if queue was empty; earliest valid at N+1.
- Throughput: one issue per cycle with no hazards and stall low.
- flush: in the flush cycle valid=0, decode_stall=0, incoming decode entry dropped; queue empty from N+1.
- stall high with valid hazard-free head: valid=0, head held, queue fills up to DEPTH, then decode_stall.
- Reset asserted mid-operation clears immediately, independent of clk.

## Configuration
- RR_FORWARD_EN defined: a hazard on source s is resolved when the governing stage i has haz_data_ok[i]=1; rs*_val_out = haz_data[i] for that source. haz_data_ok[i]=0 blocks.
- Undefined: haz_data/haz_data_ok ignored; any hazard blocks; rs*_val_out always equals the register-file value.

## Test plan
- Reset then 3 back-to-back entries rd=x1,x2,x3, no hazards, stall=0 → valid on cycles 1,2,3 after first ingest; decode_stall never asserted.
- Head rs1=x5, haz_valid=01, haz_rd[0]=5 for 2 cycles, DEPTH=2, decode_valid held → valid=0 two cycles, decode_stall rises once count=2, issue on third cycle.
- Head rs2=x0, haz_rd[1]=0 with haz_valid[1]=1 → no stall, valid same cycle.
- RR_FORWARD_EN: head rs1=x7, haz_rd[0]=7 ok=0, haz_rd[1]=7 ok=1 data=0xAA → blocked; flip ok[0]=1 data[0]=0x55 → valid, rs1_val_out=0x55.
- Exception entry (num=2) with rs1 hazard → issues immediately, exception_valid_out=1, exception_num_out=2.
- Full queue plus flush with decode_valid=1 → valid=0, decode_stall=0 that cycle; next cycle count=0, valid=0.
